// File: rtl/fixed_point_matrix_loader.sv
// fixed_point_matrix_loader: packs a serial fixed-point word stream into
// parallel A (MxN) and B (NxP) operand arrays, handed off via mat_valid/mat_ack.
module fixed_point_matrix_loader #(
    parameter int M = 8,
    parameter int N = 8,
    parameter int P = 9,
    parameter int W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [W-1:0]       in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [M*N*W-1:0]   a_mat,
    output logic [N*P*W-1:0]   b_mat,
    output logic               mat_valid,
    input  logic               mat_ack,
    output logic               frame_err,
    output logic               err_seen
);
    localparam int NA = M * N;
    localparam int NB = N * P;
    localparam int CW = $clog2(M + N + P);
    localparam int AW = $clog2(NA);
    localparam int BW = $clog2(NB);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        HOLD
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [CW-1:0] w_row_nx;
    logic [CW-1:0] w_col_nx;
    logic          r_live;
    logic          r_frame_err;
    logic          r_err_seen;
    logic [W-1:0]  r_a [NA];
    logic [W-1:0]  r_b [NB];
    logic          w_xfer;
    logic          w_wr_a;
    logic          w_wr_b;
    logic          w_err;
    logic          w_col_end;
    logic          w_row_end;
    logic [AW-1:0] w_a_idx;
    logic [BW-1:0] w_b_idx;

    // r_live holds in_ready low for the cycle in which reset is released
    assign in_ready  = r_live && (r_state != HOLD);
    assign mat_valid = (r_state == HOLD);
    assign frame_err = r_frame_err;
    assign err_seen  = r_err_seen;
    assign w_xfer    = in_valid && in_ready;
    assign w_a_idx   = AW'(int'(r_row) * N + int'(r_col));
    assign w_b_idx   = BW'(int'(r_row) * P + int'(r_col));

    always_comb begin
        w_state_nx = r_state;
        w_row_nx   = r_row;
        w_col_nx   = r_col;
        w_wr_a     = 1'b0;
        w_wr_b     = 1'b0;
        w_err      = 1'b0;
        w_col_end  = 1'b0;
        w_row_end  = 1'b0;
        unique case (r_state)
            LOAD_A: begin
                w_col_end = (r_col == CW'(N - 1));
                w_row_end = (r_row == CW'(M - 1));
                if (w_xfer) begin
                    if (in_last) begin
                        w_err    = 1'b1;
                        w_row_nx = '0;
                        w_col_nx = '0;
                    end else begin
                        w_wr_a = 1'b1;
                        if (w_col_end) begin
                            w_col_nx = '0;
                            if (w_row_end) begin
                                w_row_nx   = '0;
                                w_state_nx = LOAD_B;
                            end else begin
                                w_row_nx = r_row + CW'(1);
                            end
                        end else begin
                            w_col_nx = r_col + CW'(1);
                        end
                    end
                end
            end
            LOAD_B: begin
                w_col_end = (r_col == CW'(P - 1));
                w_row_end = (r_row == CW'(N - 1));
                if (w_xfer) begin
                    if (in_last && !(w_col_end && w_row_end)) begin
                        w_err      = 1'b1;
                        w_row_nx   = '0;
                        w_col_nx   = '0;
                        w_state_nx = LOAD_A;
                    end else begin
                        w_wr_b = 1'b1;
                        if (w_col_end && w_row_end) begin
                            // final word: a missing in_last is flagged but kept
                            w_err      = !in_last;
                            w_row_nx   = '0;
                            w_col_nx   = '0;
                            w_state_nx = HOLD;
                        end else if (w_col_end) begin
                            w_col_nx = '0;
                            w_row_nx = r_row + CW'(1);
                        end else begin
                            w_col_nx = r_col + CW'(1);
                        end
                    end
                end
            end
            HOLD: begin
                if (mat_ack) begin
                    w_row_nx   = '0;
                    w_col_nx   = '0;
                    w_state_nx = LOAD_A;
                end
            end
            default: begin
                w_row_nx   = '0;
                w_col_nx   = '0;
                w_state_nx = LOAD_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= LOAD_A;
            r_row       <= '0;
            r_col       <= '0;
            r_live      <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_seen  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_row       <= w_row_nx;
            r_col       <= w_col_nx;
            r_live      <= 1'b1;
            r_frame_err <= w_err;
            r_err_seen  <= r_err_seen | w_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NA; i++) begin
                r_a[i] <= '0;
            end
        end else if (w_wr_a) begin
            r_a[w_a_idx] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) begin
                r_b[i] <= '0;
            end
        end else if (w_wr_b) begin
            r_b[w_b_idx] <= in_data;
        end
    end

    for (genvar g = 0; g < NA; g++) begin : g_a
        assign a_mat[g*W +: W] = r_a[g];
    end

    for (genvar g = 0; g < NB; g++) begin : g_b
        assign b_mat[g*W +: W] = r_b[g];
    end

endmodule
